// File: rtl/rmii_pkg.sv
// Shared constants for the RMII receive path: FSM states, dibit codes, status bit layout and
// CRC-32 constants.
package rmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StData,
    StDrop
  } rx_state_e;

  localparam logic [1:0] DibitPre = 2'b01;
  localparam logic [1:0] DibitSfd = 2'b11;

  // rx_status = {ERR_FCS, ERR_LONG, ERR_RUNT, ERR_ALIGN/OVF}
  localparam int unsigned StatAlign = 0;
  localparam int unsigned StatRunt  = 1;
  localparam int unsigned StatLong  = 2;
  localparam int unsigned StatFcs   = 3;

  localparam logic [31:0] CrcPoly    = 32'h04C11DB7;
  localparam logic [31:0] CrcInit    = 32'hFFFFFFFF;
  localparam logic [31:0] CrcResidue = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 update (LSB of the byte first), purely combinational.
// Shared with the transmit-side FCS generator.
module crc32_d8
  import rmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] PolyRefl = bitrev32(CrcPoly);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) begin
        c = (c >> 1) ^ PolyRefl;
      end else begin
        c = c >> 1;
      end
    end
  end

  assign crc_o = c;

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII 100M receive framer: preamble/SFD hunt, dibit-to-byte packing, EOD tagging, frame status.
// Define RMII_RX_FCS_CHECK_EN to enable the CRC-32 residue check that drives ERR_FCS.
module rmii_rx_framer
  import rmii_pkg::*;
#(
  parameter int unsigned MIN_PRE_DIBITS  = 8,
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic        CRS_DV,
  input  logic        RXD0,
  input  logic        RXD1,
  input  logic        fifo_afull,
  output logic [7:0]  fifo_din,
  output logic        fifo_wren,
  output logic        fifo_EOD_in,
  output logic        rx_done,
  output logic [3:0]  rx_status,
  output logic [10:0] rx_len
);

  localparam int unsigned    PreW   = $clog2(MIN_PRE_DIBITS + 1);
  localparam logic [PreW-1:0] PreMin = PreW'(MIN_PRE_DIBITS);
  localparam logic [10:0]    MinLen = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0]    MaxLen = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0]    LenSat = 11'h7FF;

  rx_state_e       state_q, state_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [5:0]      sr_q, sr_d;
  logic [7:0]      held_q, held_d;
  logic            held_vld_q, held_vld_d;
  logic [10:0]     len_q, len_d;
  logic [7:0]      din_q, din_d;
  logic            wren_q, wren_d;
  logic            eod_q, eod_d;
  logic            done_q, done_d;
  logic [3:0]      status_q, status_d;
  logic [10:0]     rx_len_q, rx_len_d;

  logic [1:0] dibit;
  logic [7:0] byte_new;
  logic       fcs_err;

  assign dibit    = {RXD1, RXD0};
  assign byte_new = {dibit, sr_q};

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_nxt;

  crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (byte_new),
    .crc_o  (crc_nxt)
  );

  // Every completed DATA byte is folded in, including bytes past MAX_FRAME_BYTES.
  always_comb begin
    crc_d = crc_q;
    if (state_q != StData) begin
      crc_d = CrcInit;
    end else if (CRS_DV && !fifo_afull && (dcnt_q == 2'd3)) begin
      crc_d = crc_nxt;
    end
  end

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      crc_q <= CrcInit;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign fcs_err = (bitrev32(crc_q) != CrcResidue);
`else
  assign fcs_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    dcnt_d     = dcnt_q;
    sr_d       = sr_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    len_d      = len_q;
    din_d      = '0;
    wren_d     = 1'b0;
    eod_d      = 1'b0;
    done_d     = 1'b0;
    status_d   = '0;
    rx_len_d   = '0;

    case (state_q)
      StIdle: begin
        if (CRS_DV && (dibit == DibitPre)) begin
          state_d   = StPre;
          pre_cnt_d = PreW'(1);
        end
      end
      StPre: begin
        if (!CRS_DV) begin
          state_d = StIdle;
        end else if (dibit == DibitPre) begin
          if (pre_cnt_q != PreMin) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if ((dibit == DibitSfd) && (pre_cnt_q == PreMin)) begin
          state_d    = StData;
          dcnt_d     = '0;
          len_d      = '0;
          held_vld_d = 1'b0;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!CRS_DV || fifo_afull) begin
          // Carrier loss ends the frame; overflow closes it early and drains to DROP.
          state_d               = CRS_DV ? StDrop : StIdle;
          wren_d                = held_vld_q;
          eod_d                 = held_vld_q;
          din_d                 = held_vld_q ? held_q : 8'h00;
          held_vld_d            = 1'b0;
          done_d                = 1'b1;
          rx_len_d              = len_q;
          status_d[StatAlign]   = CRS_DV || (dcnt_q != 2'd0);
          status_d[StatRunt]    = (len_q < MinLen);
          status_d[StatLong]    = (len_q > MaxLen);
          status_d[StatFcs]     = fcs_err;
        end else begin
          sr_d   = {dibit, sr_q[5:2]};
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            if (len_q != LenSat) len_d = len_q + 11'd1;
            if (len_q < MaxLen) begin
              held_d     = byte_new;
              held_vld_d = 1'b1;
              if (held_vld_q) begin
                wren_d = 1'b1;
                din_d  = held_q;
              end
            end
          end
        end
      end
      StDrop: begin
        if (!CRS_DV) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      pre_cnt_q  <= '0;
      dcnt_q     <= '0;
      sr_q       <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      len_q      <= '0;
      din_q      <= '0;
      wren_q     <= 1'b0;
      eod_q      <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      rx_len_q   <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      dcnt_q     <= dcnt_d;
      sr_q       <= sr_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      len_q      <= len_d;
      din_q      <= din_d;
      wren_q     <= wren_d;
      eod_q      <= eod_d;
      done_q     <= done_d;
      status_q   <= status_d;
      rx_len_q   <= rx_len_d;
    end
  end

  assign fifo_din    = din_q;
  assign fifo_wren   = wren_q;
  assign fifo_EOD_in = eod_q;
  assign rx_done     = done_q;
  assign rx_status   = status_q;
  assign rx_len      = rx_len_q;

endmodule
